// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: command/response handshake in, five AXI channels out.
// A per-wait-state watchdog aborts a hung transaction with an error response.
module axil_cmd_master #(
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_areset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [DATA_W-1:0]     cmd_wdata,
   input  logic [DATA_W/8-1:0]   cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_timeout,
   output logic [ADDR_W-1:0]     m_axi_awaddr,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_W-1:0]     m_axi_wdata,
   output logic [DATA_W/8-1:0]   m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ADDR_W-1:0]     m_axi_araddr,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DATA_W-1:0]     m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam int unsigned CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam bit          WD_EN   = (TIMEOUT != 0);

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      RESP
   } state_t;

   state_t           state;
   logic             aw_done;
   logic             w_done;
   logic [CNT_W-1:0] wd_cnt;

   logic aw_done_c;
   logic w_done_c;
   logic wait_st_c;
   logic leave_c;
   logic timeout_c;

   // Handshake bookkeeping and watchdog decision; a normal exit wins over a same-cycle timeout.
   always_comb begin
      aw_done_c = aw_done | (m_axi_awvalid & m_axi_awready);
      w_done_c  = w_done  | (m_axi_wvalid  & m_axi_wready);
      wait_st_c = (state == WR_ADDR_DATA) || (state == WR_RESP) ||
                  (state == RD_ADDR)      || (state == RD_DATA);
      leave_c   = 1'b0;
      case (state)
         WR_ADDR_DATA: leave_c = aw_done_c & w_done_c;
         WR_RESP:      leave_c = m_axi_bvalid;
         RD_ADDR:      leave_c = m_axi_arready;
         RD_DATA:      leave_c = m_axi_rvalid;
         default:      leave_c = 1'b0;
      endcase
      timeout_c = WD_EN && wait_st_c && (wd_cnt == CNT_W'(TO_LAST)) && !leave_c;
   end

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         state         <= IDLE;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         wd_cnt        <= '0;
         cmd_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= 2'b00;
         rsp_timeout   <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
      end else begin
         if (WD_EN && wait_st_c) wd_cnt <= wd_cnt + CNT_W'(1);

         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  wd_cnt    <= '0;
                  if (cmd_write) begin
                     state         <= WR_ADDR_DATA;
                     m_axi_awaddr  <= cmd_addr;
                     m_axi_wdata   <= cmd_wdata;
                     m_axi_wstrb   <= cmd_wstrb;
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                     aw_done       <= 1'b0;
                     w_done        <= 1'b0;
                  end else begin
                     state         <= RD_ADDR;
                     m_axi_araddr  <= cmd_addr;
                     m_axi_arvalid <= 1'b1;
                  end
               end else begin
                  cmd_ready <= 1'b1;
               end
            end

            // Each channel drops its valid right after its own handshake.
            WR_ADDR_DATA: begin
               aw_done <= aw_done_c;
               w_done  <= w_done_c;
               if (aw_done_c) m_axi_awvalid <= 1'b0;
               if (w_done_c)  m_axi_wvalid  <= 1'b0;
               if (aw_done_c && w_done_c) begin
                  state        <= WR_RESP;
                  m_axi_bready <= 1'b1;
                  wd_cnt       <= '0;
               end
            end

            WR_RESP: begin
               if (m_axi_bvalid) begin
                  state        <= RESP;
                  m_axi_bready <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_resp     <= m_axi_bresp;
                  rsp_rdata    <= '0;
                  rsp_timeout  <= 1'b0;
                  wd_cnt       <= '0;
               end
            end

            RD_ADDR: begin
               if (m_axi_arready) begin
                  state         <= RD_DATA;
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  wd_cnt        <= '0;
               end
            end

            RD_DATA: begin
               if (m_axi_rvalid) begin
                  state        <= RESP;
                  m_axi_rready <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_resp     <= m_axi_rresp;
                  rsp_rdata    <= m_axi_rdata;
                  rsp_timeout  <= 1'b0;
                  wd_cnt       <= '0;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase

         // Watchdog abort overrides whatever the wait state scheduled above.
         if (timeout_c) begin
            state         <= RESP;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_resp      <= 2'b10;
            rsp_rdata     <= '0;
            rsp_timeout   <= 1'b1;
            wd_cnt        <= '0;
         end
      end
   end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed, table-driven bench for axil_cmd_master with a delay-programmable AXI4-Lite slave model.
module tb_axil_cmd_master;

   localparam int STUCK = 1000;

   logic        clk = 1'b0;
   logic        srst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [8:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [8:0]  awaddr, araddr;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   axil_cmd_master #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(16)) dut (
      .s_axi_aclk(clk), .s_axi_areset(srst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   always #5 clk = ~clk;

   // Slave model: each ready rises after its valid has waited the programmed number of cycles.
   int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
   logic [1:0]  s_resp;
   logic [31:0] s_rdata;
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   int          aw_hs, w_hs, ar_hs, r_hs;
   logic        aw_got, w_got, b_pend, r_pend;
   logic        aw_now, w_now;

   always_comb begin
      awready = (aw_cnt >= aw_wait);
      wready  = (w_cnt  >= w_wait);
      arready = (ar_cnt >= ar_wait);
      bvalid  = b_pend && (b_cnt >= b_wait);
      rvalid  = r_pend && (r_cnt >= r_wait);
      aw_now  = aw_got | (awvalid & awready);
      w_now   = w_got  | (wvalid & wready);
   end
   assign bresp = s_resp;
   assign rresp = s_resp;
   assign rdata = s_rdata;

   always @(posedge clk) begin
      if (srst) begin
         aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
         aw_hs <= 0; w_hs <= 0; ar_hs <= 0; r_hs <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      end else begin
         if (awvalid && awready) begin aw_cnt <= 0; aw_hs <= aw_hs + 1; end
         else if (awvalid) aw_cnt <= aw_cnt + 1;
         if (wvalid && wready) begin w_cnt <= 0; w_hs <= w_hs + 1; end
         else if (wvalid) w_cnt <= w_cnt + 1;
         if (aw_now && w_now && !b_pend) begin
            b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
         end else begin
            aw_got <= aw_now; w_got <= w_now;
         end
         if (b_pend) begin
            if (bvalid && bready) b_pend <= 1'b0;
            else b_cnt <= b_cnt + 1;
         end
         if (arvalid && arready) begin
            ar_cnt <= 0; ar_hs <= ar_hs + 1; r_pend <= 1'b1; r_cnt <= 0;
         end else if (arvalid) ar_cnt <= ar_cnt + 1;
         if (r_pend) begin
            if (rvalid && rready) begin r_pend <= 1'b0; r_hs <= r_hs + 1; end
            else r_cnt <= r_cnt + 1;
         end
      end
   end

   // Protocol monitor: a pending valid must not drop and its payload must not move.
   bit          allow_drop;
   int          prot_err;
   logic        p_rst, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
   logic [8:0]  p_awaddr, p_araddr;
   logic [31:0] p_wdata;
   logic [3:0]  p_wstrb;

   always @(negedge clk) begin
      p_rst <= srst;
      p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
      p_wv  <= wvalid;  p_wr  <= wready;  p_wdata <= wdata; p_wstrb <= wstrb;
      p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
      if (!srst && !p_rst && !allow_drop) begin
         if ((p_awv && !p_awr && (!awvalid || awaddr !== p_awaddr)) ||
             (p_wv  && !p_wr  && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) ||
             (p_arv && !p_arr && (!arvalid || araddr !== p_araddr)))
            prot_err <= prot_err + 1;
      end
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] all_outs();
      return {cmd_ready, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata,
              awvalid, wvalid, arvalid, bready, rready, awaddr, wdata, wstrb, araddr};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      srst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      srst = 1'b0;
   endtask

   // Present a command and return #1 after the accepting edge (T0).
   task automatic send_cmd(input bit wr, input logic [8:0] a, input logic [31:0] d,
                           input logic [3:0] s, output bit ok);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
      end
      cmd_valid = 1'b0;
      if (!ok) chk("cmd_accept_timeout", 128'd0, 128'd1);
   endtask

   // Wait for rsp_valid; returns the edge index (from T0) at which it can handshake.
   task automatic wait_rsp(output int hs_edge);
      int lat = 0;
      hs_edge = -1;
      for (int i = 0; i < 100; i++) begin
         if (rsp_valid) begin hs_edge = lat + 1; break; end
         @(posedge clk); #1;
         lat++;
      end
      if (hs_edge < 0) chk("rsp_wait_timeout", 128'd0, 128'd1);
   endtask

   typedef struct {
      bit          wr;
      logic [8:0]  addr;
      logic [31:0] wdat;
      logic [3:0]  strb;
      int          aw_w, w_w, b_w, ar_w, r_w;
      logic [1:0]  sresp;
      logic [31:0] srdata;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      bit          exp_to;
      int          exp_lat;
      int          exp_hs0, exp_hs1;
   } vec_t;

   vec_t tbl[9];

   initial begin
      bit          ok;
      int          hs_edge;
      int          bad;
      int          seen;
      logic [34:0] snap;

      srst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0; allow_drop = 1'b0; prot_err = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      s_resp = 2'b00; s_rdata = 32'h0;

      //             wr addr    wdata         strb  aw w  b  ar     r  sresp srdata       exp_rdata    resp to lat hs0 hs1
      tbl[0] = '{1'b1, 9'h004, 32'hA5A5_0000, 4'hF, 0, 0, 0, 0,     0, 2'b00, 32'hFFFF_FFFF, 32'h0,        2'b00, 1'b0, 3,  1, 1};
      tbl[1] = '{1'b0, 9'h008, 32'h0,         4'h0, 0, 0, 0, 0,     5, 2'b00, 32'h1234_5678, 32'h1234_5678, 2'b00, 1'b0, 8,  1, 1};
      tbl[2] = '{1'b1, 9'h00C, 32'hDEAD_BEEF, 4'h3, 3, 0, 0, 0,     0, 2'b10, 32'hFFFF_FFFF, 32'h0,        2'b10, 1'b0, 6,  1, 1};
      tbl[3] = '{1'b1, 9'h1F0, 32'h0F0F_1234, 4'h8, 0, 2, 1, 0,     0, 2'b00, 32'h7777_7777, 32'h0,        2'b00, 1'b0, 6,  1, 1};
      tbl[4] = '{1'b0, 9'h100, 32'h0,         4'h0, 0, 0, 0, 2,     0, 2'b11, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'b11, 1'b0, 5,  1, 1};
      tbl[5] = '{1'b0, 9'h010, 32'h0,         4'h0, 0, 0, 0, STUCK, 0, 2'b00, 32'h5555_5555, 32'h0,        2'b10, 1'b1, 17, 0, 0};
      tbl[6] = '{1'b1, 9'h014, 32'h8765_4321, 4'hF, STUCK, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        2'b10, 1'b1, 17, 0, 1};
      tbl[7] = '{1'b1, 9'h018, 32'h1357_9BDF, 4'h1, 0, 0, STUCK, 0, 0, 2'b00, 32'h0,        32'h0,        2'b10, 1'b1, 18, 1, 1};
      tbl[8] = '{1'b0, 9'h1FC, 32'h0,         4'h0, 0, 0, 0, 0,     0, 2'b01, 32'h0000_55AA, 32'h0000_55AA, 2'b01, 1'b0, 3,  1, 1};

      // Outputs while reset is held.
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", all_outs(), 128'd0);

      for (int i = 0; i < 9; i++) begin
         aw_wait = tbl[i].aw_w; w_wait = tbl[i].w_w; b_wait = tbl[i].b_w;
         ar_wait = tbl[i].ar_w; r_wait = tbl[i].r_w;
         s_resp = tbl[i].sresp; s_rdata = tbl[i].srdata;
         allow_drop = tbl[i].exp_to;
         prot_err = 0;
         do_reset();
         send_cmd(tbl[i].wr, tbl[i].addr, tbl[i].wdat, tbl[i].strb, ok);
         if (tbl[i].wr)
            chk($sformatf("v%0d_t1_aw_w", i), {awvalid, wvalid, awaddr, wdata, wstrb},
                {1'b1, 1'b1, tbl[i].addr, tbl[i].wdat, tbl[i].strb});
         else
            chk($sformatf("v%0d_t1_ar", i), {arvalid, araddr}, {1'b1, tbl[i].addr});
         wait_rsp(hs_edge);
         chk($sformatf("v%0d_latency", i), hs_edge, tbl[i].exp_lat);
         chk($sformatf("v%0d_rdata", i), rsp_rdata, tbl[i].exp_rdata);
         chk($sformatf("v%0d_resp", i), rsp_resp, tbl[i].exp_resp);
         chk($sformatf("v%0d_timeout", i), rsp_timeout, tbl[i].exp_to);
         chk($sformatf("v%0d_resp_valids_low", i), {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         rsp_ready = 1'b0;
         chk($sformatf("v%0d_after_hs", i), {rsp_valid, cmd_ready}, 2'b01);
         if (tbl[i].wr)
            chk($sformatf("v%0d_aw_w_hs", i), {aw_hs[7:0], w_hs[7:0]},
                {8'(tbl[i].exp_hs0), 8'(tbl[i].exp_hs1)});
         else
            chk($sformatf("v%0d_ar_r_hs", i), {ar_hs[7:0], r_hs[7:0]},
                {8'(tbl[i].exp_hs0), 8'(tbl[i].exp_hs1)});
         chk($sformatf("v%0d_protocol", i), prot_err, 0);
      end
      allow_drop = 1'b0;

      // rsp_ready held low 10 cycles with a second command already waiting.
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      s_resp = 2'b00; s_rdata = 32'h0BAD_F00D;
      prot_err = 0;
      do_reset();
      send_cmd(1'b1, 9'h020, 32'h1111_2222, 4'hF, ok);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h024;
      wait_rsp(hs_edge);
      chk("hold_latency", hs_edge, 3);
      snap = {rsp_timeout, rsp_resp, rsp_rdata};
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || arvalid !== 1'b0 ||
             {rsp_timeout, rsp_resp, rsp_rdata} !== snap)
            bad++;
      end
      chk("hold_stable", bad, 0);
      chk("hold_resp", snap, 35'd0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("hold_release", {rsp_valid, cmd_ready, arvalid}, 3'b010);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("hold_next_accept", {cmd_ready, arvalid, araddr}, {1'b0, 1'b1, 9'h024});
      wait_rsp(hs_edge);
      chk("hold_next_latency", hs_edge, 3);
      chk("hold_next_rdata", {rsp_resp, rsp_rdata}, {2'b00, 32'h0BAD_F00D});
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("hold_protocol", prot_err, 0);

      // Reset pulsed while waiting in WR_RESP abandons the write silently.
      b_wait = STUCK;
      do_reset();
      send_cmd(1'b1, 9'h030, 32'hFACE_B00C, 4'hF, ok);
      for (int k = 0; k < 20; k++) begin
         if (bready) break;
         @(posedge clk); #1;
      end
      chk("rst_in_wr_resp", {bready, awvalid, wvalid}, 3'b100);
      @(negedge clk);
      srst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_outputs", all_outs(), 128'd0);
      @(negedge clk);
      srst = 1'b0;
      @(posedge clk); #1;
      chk("rst_release_ready", {cmd_ready, rsp_valid}, 2'b10);
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) seen++;
      end
      chk("rst_no_response", seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

Single-outstanding AXI4-Lite master that turns simple command/response handshakes into full AXI4-Lite read and write transactions. It sits directly upstream of the AXI GPIO slave: its m_axi_* outputs drive the GPIO s_axi_* inputs. Sequence or stimulus logic can then access GPIO registers without implementing the five-channel protocol itself. A per-transaction watchdog reports a hung slave instead of stalling forever.

## Interface
Parameters:
- ADDR_W, 9, address width; matches the GPIO register space.
- DATA_W, 32, data width; the strobe width is DATA_W/8.
- TIMEOUT, 256, maximum cycles spent in any single AXI wait state; 0 disables the watchdog.

Ports:
- s_axi_aclk  in  1  single clock; all logic is on the rising edge.
- s_axi_areset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- cmd_wstrb  in  DATA_W/8  write strobes; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  the transaction was aborted by the watchdog.
- m_axi_awaddr/awvalid out, m_axi_awready in: AW channel.
- m_axi_wdata/wstrb/wvalid out, m_axi_wready in: W channel.
- m_axi_bresp/bvalid in, m_axi_bready out: B channel.
- m_axi_araddr/arvalid out, m_axi_arready in: AR channel.
- m_axi_rdata/rresp/rvalid in, m_axi_rready out: R channel.

## Operation
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE
  - cmd_ready = 1.
  - On cmd_valid: latch addr, wdata and wstrb.
  - Go to WR_ADDR_DATA if cmd_write, else RD_ADDR.
- WR_ADDR_DATA
  - awvalid and wvalid assert together.
  - Each channel is tracked by its own done flag. A channel's valid drops the cycle after its own handshake and is never re-raised.
  - When both flags are set, go to WR_RESP.
- WR_RESP
  - bready = 1.
  - On bvalid: capture bresp, go to RESP.
- RD_ADDR
  - arvalid = 1.
  - On arready: go to RD_DATA.
- RD_DATA
  - rready = 1.
  - On rvalid: capture rdata and rresp, go to RESP.
- RESP
  - rsp_valid = 1; all rsp_* outputs are held stable.
  - On rsp_ready: go to IDLE.
- AXI stability rules:
  - awaddr, wdata, wstrb and araddr are stable while their valid is high.
  - A valid never drops before its handshake, except on timeout.
  - Valids never depend combinationally on the ready inputs.
- Watchdog
  - The counter clears on every state change and increments in all states except IDLE and RESP.
  - When it reaches TIMEOUT:
    - drop all AXI valids and readies;
    - rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0;
    - go to RESP.
  - After a timeout the slave must be reset before further use.
- Reset
  - Clears the FSM to IDLE and zeroes every output: cmd_ready, rsp_*, and all m_axi_* valids, readies, address, data and strobe.
  - Reset asserted mid-transaction abandons the transaction with no response.

## Timing
- cmd_ready is registered as state==IDLE. It is 0 during reset and 1 on the first cycle after reset deasserts.
- Command accepted at edge T0 → awvalid/wvalid or arvalid high from T1.
- Zero-wait slave, write:
  - AW and W handshake at T1.
  - bready high at T2; bvalid at T2.
  - rsp_valid at T3.
- Zero-wait slave, read:
  - arvalid at T1 with arready at T1.
  - rready at T2; rvalid at T2.
  - rsp_valid at T3.
- Minimum command-to-response latency is 3 cycles. After the RESP handshake, IDLE (cmd_ready = 1) follows on the next cycle.
- Back-to-back throughput is one transaction per 4 cycles at best.
- Skewed write handshakes:
  - AW and W may handshake in the same cycle or in different cycles, in either order.
  - WR_RESP is entered the cycle after the later handshake.
- Ready asserted before valid (slave pre-ready) handshakes in the first valid cycle.
- Timeout fires exactly TIMEOUT cycles after entering the wait state. With TIMEOUT=4, a stuck awready gives awvalid high for 4 cycles, then rsp_valid on the next cycle.

## Test plan
- Write addr 0x004, data 0xA5A5_0000, wstrb 0xF, zero-wait slave → awaddr=0x004 and wdata=0xA5A5_0000 at T1; rsp_valid at T3 with rsp_resp=0, rsp_rdata=0.
- Read addr 0x008; slave returns rdata 0x1234_5678, rresp 0 after 5 wait cycles on R → rsp_rdata=0x1234_5678, rsp_resp=0, rsp_timeout=0.
- Write with wready 3 cycles before awready → wvalid drops after its handshake while awvalid stays high; exactly one handshake per channel; BRESP 2'b10 from the slave reports as rsp_resp=2'b10, rsp_timeout=0.
- TIMEOUT=16, arready held 0 → arvalid deasserts after 16 cycles; rsp_resp=2'b10, rsp_timeout=1.
- rsp_ready held low 10 cycles → rsp_* stable and cmd_ready=0 throughout; a following command is accepted only after the handshake.
- s_axi_areset pulsed in WR_RESP → all outputs 0 the next cycle, no response emitted, cmd_ready=1 after release.
